// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage.
//
// Holds the PC, fetches one instruction word at a time from instruction
// memory over a req/ack handshake with variable latency, presents the word
// to decode over a valid/ready handshake, and computes the next fetch
// address from the decode outcome (PCsrc/ImmExt for beq, else pc+4).
// A misaligned next-PC target halts the unit with a sticky fault until reset.
//
// Handshakes:
//   imem: imem_req is held high with imem_addr constant until imem_ack=1 is
//         seen; imem_ack while imem_req=0 is ignored.
//   decode: a transfer happens on any rising edge where instr_valid and
//         instr_ready are both 1; instr/pc are stable until then. PCsrc and
//         ImmExt are only looked at on that transfer edge.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   imem_req, imem_addr   fetch request and address (outputs)
//   imem_ack, imem_rdata  memory response (inputs)
//   instr, pc             registered instruction and its address (outputs)
//   instr_valid           instr/pc hold a valid instruction (output)
//   instr_ready           decode accepts instr this cycle (input)
//   PCsrc, ImmExt         branch taken / sign-extended offset (inputs)
//   fault                 sticky misaligned-target flag (output)
//   state                 current FSM state, for debug/observation (output)
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  PCsrc,
    input  logic [ADDR_WIDTH-1:0] ImmExt,
    output logic                  fault,
    output logic [1:0]            state
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    logic [1:0]            state_q;
    logic                  handshake;
    logic [ADDR_WIDTH-1:0] target;

    assign handshake = (state_q == ST_HOLD) && instr_valid && instr_ready;
    // Plain modulo-2^ADDR_WIDTH add: backward branches wrap naturally.
    assign target    = PCsrc ? (pc + ImmExt) : (pc + PC_STEP);
    assign state     = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FETCH;
            imem_addr   <= RESET_PC;
            imem_req    <= 1'b0;
            instr       <= '0;
            pc          <= '0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    // Coming out of reset req is low: raise it first. An ack
                    // seen while req is low (e.g. a late response to a request
                    // abandoned by reset) is dropped here.
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        instr       <= imem_rdata;
                        pc          <= imem_addr;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state_q     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (handshake) begin
                        instr_valid <= 1'b0;
                        if (target[1:0] == 2'b00) begin
                            imem_addr <= target;
                            imem_req  <= 1'b1;
                            state_q   <= ST_FETCH;
                        end else begin
                            fault    <= 1'b1;
                            imem_req <= 1'b0;
                            state_q  <= ST_HALT;
                        end
                    end
                end
                default: begin
                    // HALT (and the unused encoding): everything frozen until reset.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed bench for fetch_unit.
// A table of fetch/handshake records walks the unit through sequential,
// taken/not-taken, backward and wrapping branches with wait states and
// stalls; hand-written sequences cover the misaligned halt and reset
// during an outstanding request. A monitor checks imem_addr is stable
// while imem_req stays high.
module tb_fetch_unit;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        PCsrc = 1'b0;
  logic [31:0] ImmExt = '0;
  logic        fault;
  logic [1:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] word;
    logic [31:0] addr;
    int          delay;
    int          stall;
    logic        pcsrc;
    logic [31:0] imm;
    logic [31:0] next;
  } vec_t;

  vec_t vecs[10];

  fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .pc(pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .PCsrc(PCsrc), .ImmExt(ImmExt),
    .fault(fault), .state(state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // imem_addr must not move while a request is outstanding
  logic        last_req = 1'b0;
  logic [31:0] last_addr = '0;
  always @(negedge clk) begin
    if (rst_n && last_req && imem_req)
      check("addr_stable_during_req", imem_addr, last_addr);
    last_req  <= rst_n && imem_req;
    last_addr <= imem_addr;
  end

  task automatic check_reset_values();
    check("rst_state", 32'(state), 32'(S_FETCH));
    check("rst_addr", imem_addr, 32'h0);
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
  endtask

  // Called just after a negedge. Waits (bounded) for a request, applies
  // `delay` wait states, then acks with `word`.
  task automatic do_fetch(input logic [31:0] word, input int delay, input logic [31:0] addr);
    int guard = 0;
    while (!imem_req && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("req_seen", 32'(imem_req), 32'h1);
    check("fetch_addr", imem_addr, addr);
    for (int i = 0; i < delay; i++) begin
      imem_ack = 1'b0;
      @(negedge clk);
      check("req_held_wait", 32'(imem_req), 32'h1);
      check("valid_low_wait", 32'(instr_valid), 32'h0);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    check("valid_after_ack", 32'(instr_valid), 32'h1);
    check("instr_captured", instr, word);
    check("pc_captured", pc, addr);
    check("req_drop_after_ack", 32'(imem_req), 32'h0);
    check("state_hold", 32'(state), 32'(S_HOLD));
  endtask

  // Stalls for `stall` cycles with junk on the ignored inputs, then
  // completes one handshake and checks the very next cycle re-requests.
  task automatic do_handshake(input logic [31:0] word, input logic [31:0] addr, input int stall,
                              input logic pcsrc, input logic [31:0] imm, input logic [31:0] next);
    for (int i = 0; i < stall; i++) begin
      instr_ready = 1'b0;
      PCsrc       = 1'($urandom_range(1, 0));
      ImmExt      = $urandom;
      imem_ack    = 1'b1;
      imem_rdata  = $urandom;
      @(negedge clk);
      check("stall_valid", 32'(instr_valid), 32'h1);
      check("stall_instr", instr, word);
      check("stall_pc", pc, addr);
      check("stall_req", 32'(imem_req), 32'h0);
    end
    imem_ack    = 1'b0;
    instr_ready = 1'b1;
    PCsrc       = pcsrc;
    ImmExt      = imm;
    @(negedge clk);
    instr_ready = 1'b0;
    PCsrc       = 1'b0;
    ImmExt      = $urandom;
    check("hs_valid_drop", 32'(instr_valid), 32'h0);
    check("hs_req_next", 32'(imem_req), 32'h1);
    check("hs_next_addr", imem_addr, next);
    check("hs_no_fault", 32'(fault), 32'h0);
    check("hs_state_fetch", 32'(state), 32'(S_FETCH));
  endtask

  initial begin
    //              word          addr          dly stl pcsrc imm           next
    vecs[0] = '{32'h0000_0013, 32'h0000_0000, 0, 0, 1'b0, 32'h0000_0000, 32'h0000_0004};
    vecs[1] = '{32'h0050_0093, 32'h0000_0004, 0, 0, 1'b0, 32'h0000_0000, 32'h0000_0008};
    vecs[2] = '{32'h0000_0013, 32'h0000_0008, 0, 0, 1'b1, 32'h0000_0008, 32'h0000_0010};
    vecs[3] = '{32'h0020_8463, 32'h0000_0010, 3, 4, 1'b1, 32'h0000_0008, 32'h0000_0018};
    vecs[4] = '{32'h0000_0013, 32'h0000_0018, 1, 0, 1'b1, 32'hFFFF_FFF8, 32'h0000_0010};
    vecs[5] = '{32'h0020_8463, 32'h0000_0010, 0, 2, 1'b0, 32'h0000_0008, 32'h0000_0014};
    vecs[6] = '{32'h0000_0013, 32'h0000_0014, 2, 1, 1'b1, 32'hFFFF_FFF0, 32'h0000_0004};
    vecs[7] = '{32'h0020_8463, 32'h0000_0004, 0, 0, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC};
    vecs[8] = '{32'h0000_0013, 32'hFFFF_FFFC, 0, 0, 1'b0, 32'h1234_5678, 32'h0000_0000};
    vecs[9] = '{32'h0050_0093, 32'h0000_0000, 0, 0, 1'b1, 32'h0000_0020, 32'h0000_0020};

    // reset
    repeat (2) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    @(negedge clk);
    check("req_after_reset", 32'(imem_req), 32'h1);
    check("addr_after_reset", imem_addr, 32'h0);

    // table
    for (int i = 0; i < 10; i++) begin
      do_fetch(vecs[i].word, vecs[i].delay, vecs[i].addr);
      do_handshake(vecs[i].word, vecs[i].addr, vecs[i].stall,
                   vecs[i].pcsrc, vecs[i].imm, vecs[i].next);
    end

    // misaligned target from 0x20 -> HALT
    do_fetch(32'h0020_8463, 0, 32'h0000_0020);
    instr_ready = 1'b1;
    PCsrc       = 1'b1;
    ImmExt      = 32'h0000_0002;
    @(negedge clk);
    check("halt_fault", 32'(fault), 32'h1);
    check("halt_state", 32'(state), 32'(S_HALT));
    check("halt_req", 32'(imem_req), 32'h0);
    check("halt_valid", 32'(instr_valid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      instr_ready = 1'($urandom_range(1, 0));
      imem_ack    = 1'b1;
      imem_rdata  = $urandom;
      PCsrc       = 1'($urandom_range(1, 0));
      ImmExt      = $urandom;
      @(negedge clk);
      check("halt_frozen_state", 32'(state), 32'(S_HALT));
      check("halt_frozen_fault", 32'(fault), 32'h1);
      check("halt_frozen_req", 32'(imem_req), 32'h0);
      check("halt_frozen_valid", 32'(instr_valid), 32'h0);
      check("halt_frozen_instr", instr, 32'h0020_8463);
      check("halt_frozen_pc", pc, 32'h0000_0020);
      check("halt_frozen_addr", imem_addr, 32'h0000_0020);
    end
    instr_ready = 1'b0;
    imem_ack    = 1'b0;
    PCsrc       = 1'b0;

    // reset out of HALT, asynchronously (mid-cycle)
    #2 rst_n = 1'b0;
    #1 check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("req_after_halt_reset", 32'(imem_req), 32'h1);
    do_fetch(32'h0000_0013, 0, 32'h0000_0000);
    do_handshake(32'h0000_0013, 32'h0000_0000, 0, 1'b1, 32'h0000_0040, 32'h0000_0040);

    // reset with an outstanding request at 0x40; late ack must be ignored
    @(negedge clk);
    check("req_outstanding_40", 32'(imem_req), 32'h1);
    #2 rst_n = 1'b0;
    #1 check_reset_values();
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    check("late_ack_ignored_valid", 32'(instr_valid), 32'h0);
    check("late_ack_ignored_instr", instr, 32'h0);
    check("restart_req", 32'(imem_req), 32'h1);
    check("restart_addr", imem_addr, 32'h0);
    do_fetch(32'h0050_0093, 0, 32'h0000_0000);
    do_handshake(32'h0050_0093, 32'h0000_0000, 0, 1'b0, 32'h0, 32'h0000_0004);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage; produces the instruction stream that the control unit decodes (opcode is instr[6:0]).
- Holds the PC and issues requests to instruction memory over a req/ack handshake with variable latency.
- Presents each fetched word to decode over a valid/ready handshake.
- Computes the next PC from the decode/ALU outcome: PCsrc and ImmExt, covering beq and the fall-through case.

Parameters:
ADDR_WIDTH, 32, width of PC and imem_addr
DATA_WIDTH, 32, instruction word width
RESET_PC, 32'h0000_0000, first fetch address after reset (must be 4-byte aligned)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  request to instruction memory
imem_addr  output  ADDR_WIDTH  fetch address; stable while imem_req=1
imem_ack  input  1  memory returns imem_rdata this cycle
imem_rdata  input  DATA_WIDTH  instruction word, valid when imem_ack=1
instr  output  DATA_WIDTH  registered instruction to decode
pc  output  ADDR_WIDTH  address of the word currently in instr
instr_valid  output  1  instr/pc hold a valid instruction
instr_ready  input  1  decode consumes instr this cycle
PCsrc  input  1  branch taken for the consumed instruction; sampled only on handshake
ImmExt  input  ADDR_WIDTH  sign-extended branch offset; sampled only on handshake
fault  output  1  sticky misaligned-target flag

Behaviour:
- Reset (rst_n=0, async): state=FETCH; imem_addr=RESET_PC; imem_req=0; instr=0; pc=0; instr_valid=0; fault=0.
- First cycle after rst_n deasserts: imem_req=1.
- All outputs are registered.
- States: FETCH, HOLD, HALT.
- FETCH:
  - imem_req=1, imem_addr constant.
  - On imem_ack=1: instr<=imem_rdata, pc<=imem_addr, instr_valid<=1, imem_req<=0, go HOLD.
  - imem_ack=0: remain in FETCH; there is no timeout.
- HOLD:
  - instr_valid=1; instr and pc stable until the handshake.
  - Handshake = instr_valid & instr_ready.
  - On handshake: target = PCsrc ? pc+ImmExt : pc+4, computed modulo 2^ADDR_WIDTH (wrap, no overflow flag).
  - If target[1:0]==0: imem_addr<=target, imem_req<=1, instr_valid<=0, go FETCH.
  - If target[1:0]!=0: fault<=1, instr_valid<=0, imem_req<=0, go HALT.
- HALT: all handshakes inert, outputs frozen; exit only via reset.
- Throughput: with 1-cycle ack and ready held high, one instruction per 2 cycles:
  - req at cycle N, ack at N, valid at N+1, handshake at N+1, req at N+2.
- Ignored inputs:
  - imem_ack when imem_req=0 is ignored; imem_rdata is not captured.
  - PCsrc and ImmExt outside the handshake cycle have no effect.
- Branch-only scope: a negative ImmExt is valid and wraps correctly, e.g. pc=0x4, ImmExt=-8 gives 0xFFFF_FFFC.
- Reset mid-operation:
  - Asserting rst_n during FETCH with an outstanding request abandons the request.
  - A later late ack is ignored because imem_req=0 after reset.
- imem_addr does not change while imem_req=1. The bench asserts this.

Test Plan:
- Reset and sequential fetch: RESET_PC=0, memory acks same cycle with words 0x00000013, 0x00500093, ready held 1 -> handshakes at pc=0x0 then 0x4; instr matches; next imem_addr=0x8.
- Taken beq: instr=0x00208463 at pc=0x10, handshake with PCsrc=1, ImmExt=0x8 -> next imem_addr=0x18. Same with PCsrc=0 -> 0x14.
- Backpressure and wait states: ack delayed 3 cycles, then ready held 0 for 4 cycles -> imem_addr stable across the wait; instr/pc/instr_valid stable across the stall; exactly one handshake.
- Backward branch and wrap: pc=0x4, PCsrc=1, ImmExt=0xFFFF_FFF8 -> imem_addr=0xFFFF_FFFC, no fault. Then not-taken from 0xFFFF_FFFC -> 0x0000_0000.
- Misaligned target: pc=0x20, PCsrc=1, ImmExt=0x2 -> fault=1, state HALT, imem_req=0, instr_valid=0. Further ready/ack have no effect until rst_n low.
- Reset mid-request: rst_n pulsed low while in FETCH at 0x40 -> all outputs return to reset values immediately. An ack arriving during reset is ignored. Fetching restarts at RESET_PC.
